alu_seq_nbit: RTL

ALU_SEQ_NBIT -- requirements
Module: alu_seq_nbit

---
 rtl/alu_seq_nbit.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit: handshaked ALU with single-cycle ops and a WIDTH-cycle shift-add multiplier.
module alu_seq_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Cout,
    output logic             Zero,
    output logic             Ovf
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
    logic [WIDTH-1:0]   mplier, y_alu;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum, diff;
    logic               accept, last, c_alu, o_alu;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign last      = cnt == LAST;
    assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? ((sel == 3'b101) ? BUSY : DONE) : IDLE;
            BUSY:    state_nxt = last ? DONE : BUSY;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle ops evaluate straight from the inputs so the result lands on the accepting edge.
    always_comb begin
        sum   = {1'b0, A} + {1'b0, B};
        diff  = {1'b0, A} - {1'b0, B};
        y_alu = '0;
        c_alu = 1'b0;
        o_alu = 1'b0;
        case (sel)
            3'b000: begin
                y_alu = sum[WIDTH-1:0];
                c_alu = sum[WIDTH];
                o_alu = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            3'b001: begin
                y_alu = diff[WIDTH-1:0];
                c_alu = ~diff[WIDTH];
                o_alu = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            3'b010:  y_alu = A & B;
            3'b011:  y_alu = A | B;
            3'b100:  y_alu = A ^ B;
            3'b110:  y_alu = A;
            default: y_alu = '0;
        endcase
    end

    // mcand/mplier hold the captured operands; the multiplier consumes them one bit per cycle.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            Y      <= '0;
            Cout   <= 1'b0;
            Zero   <= 1'b0;
            Ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mcand  <= {{WIDTH{1'b0}}, A};
                    mplier <= B;
                    acc    <= '0;
                    cnt    <= '0;
                    if (sel != 3'b101) begin
                        Y    <= y_alu;
                        Cout <= c_alu;
                        Ovf  <= o_alu;
                        Zero <= y_alu == '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        Y    <= acc_nxt[WIDTH-1:0];
                        Cout <= |acc_nxt[2*WIDTH-1:WIDTH];
                        Ovf  <= 1'b0;
                        Zero <= acc_nxt[WIDTH-1:0] == '0;
                    end
                end
                default: ;
            endcase
        end
endmodule
